imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Fills instruction memory from a byte stream before the CPU is released.
// Stream format: a 16-bit word count (high byte first), then count*4
// instruction bytes. Each word is big-endian: its first byte lands in
// bits [31:24]. Every word goes out as one write at a word-aligned byte
// address, starting at BASE_ADDR. The CPU is held stopped until the load
// completes.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_i       one-cycle load request; honoured in IDLE, DONE or ERR
//   in_valid_i    in_data_i holds a byte
//   in_data_i     stream byte
//   in_ready_o    loader can take a byte this cycle
//   imem_we_o     one-cycle instruction memory write strobe
//   imem_addr_o   write byte address (word-aligned)
//   imem_wdata_o  write word
//   busy_o        load in progress (LEN_HI, LEN_LO, DATA, WRITE)
//   done_o        load completed; held until next start or reset
//   err_o         word count exceeded DEPTH; held until next start or reset
//   cpu_run_o     CPU enable; equals done_o
//   dbg_state_o   current FSM state encoding
//
// Handshake: a byte transfers on the rising edge where in_valid_i and
// in_ready_o are both high. in_ready_o depends only on the state, never on
// in_valid_i. The producer may hold in_valid_i low for any number of cycles,
// and a byte presented while in_ready_o is low is not consumed.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_run_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // One bit wider than the count, so a DEPTH of 65536 still compares correctly.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state_q;
  logic [7:0]  count_hi_q;    // high byte of the word count
  logic [15:0] words_left_q;  // words still to be written
  logic [1:0]  byte_cnt_q;    // byte position inside the current word
  logic [23:0] asm_q;         // first three bytes of the word being assembled
  logic [31:0] addr_q;        // address of the next word to write
  logic        imem_we_q;
  logic [31:0] imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        done_q;
  logic        err_q;

  logic        accept;
  logic [15:0] count_d;       // full count once the low byte arrives
  logic [31:0] word_d;        // complete word once the 4th byte arrives

  assign in_ready_o = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA);
  assign busy_o     = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_WRITE);
  assign accept     = in_valid_i && in_ready_o;
  assign count_d    = {count_hi_q, in_data_i};
  assign word_d     = {asm_q, in_data_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_hi_q   <= 8'd0;
      words_left_q <= 16'd0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      addr_q       <= BASE_ADDR;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q    <= S_LEN_HI;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= BASE_ADDR;
            byte_cnt_q <= 2'd0;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            count_hi_q <= in_data_i;
            state_q    <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            if (count_d == 16'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if ({1'b0, count_d} > DEPTH_L) begin
              // Rejected before DATA, so addr_q never walks past the memory.
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              words_left_q <= count_d;
              state_q      <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            asm_q      <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_wdata_q <= word_d;
              imem_addr_q  <= addr_q;
              imem_we_q    <= 1'b1;
              state_q      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          imem_we_q    <= 1'b0;
          addr_q       <= addr_q + 32'd4;
          words_left_q <= words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_DATA;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_run_o    = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader: directed bench for imem_loader (DEPTH=256, BASE_ADDR=0).
// A write monitor pops expected (addr, data) pairs from a queue on every
// imem_we pulse; the main sequence checks status outputs and cycle timing.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        cpu_run_o;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int wr_base;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_run_o    (cpu_run_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // ---------------- write scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && imem_we_o) begin
      logic [31:0] a;
      logic [31:0] d;
      wr_cnt++;
      check("ready_low_in_write", {31'd0, in_ready_o}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        a = exp_addr_q.pop_front();
        d = exp_q.pop_front();
        check("wr_addr", imem_addr_o, a);
        check("wr_data", imem_wdata_o, d);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Presents one byte until accepted; optional random idle cycles first.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit acc;
    acc = 1'b0;
    if (stall) begin
      int n;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = b;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready_o;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    #1 in_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    send_byte(w[31:24], stall);
    send_byte(w[23:16], stall);
    send_byte(w[15:8],  stall);
    send_byte(w[7:0],   stall);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready_o}, 32'd0);
    check({tag, "_we"},    {31'd0, imem_we_o},  32'd0);
    check({tag, "_addr"},  imem_addr_o,         32'h0);
    check({tag, "_wdata"}, imem_wdata_o,        32'h0);
    check({tag, "_busy"},  {31'd0, busy_o},     32'd0);
    check({tag, "_done"},  {31'd0, done_o},     32'd0);
    check({tag, "_err"},   {31'd0, err_o},      32'd0);
    check({tag, "_run"},   {31'd0, cpu_run_o},  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // A: count=2, continuous stream, exact pulse/done timing
    exp_addr_q.push_back(32'h0); exp_q.push_back(32'h2008_0005);
    exp_addr_q.push_back(32'h4); exp_q.push_back(32'h0109_5020);
    wr_base = wr_cnt;
    pulse_start();
    @(negedge clk);
    check("a_busy_after_start",  {31'd0, busy_o},     32'd1);
    check("a_ready_after_start", {31'd0, in_ready_o}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'h0109_5020, 1'b0);
    @(negedge clk);
    check("a_last_we",        {31'd0, imem_we_o}, 32'd1);
    check("a_done_not_yet",   {31'd0, done_o},    32'd0);
    @(negedge clk);
    check("a_done",           {31'd0, done_o},    32'd1);
    check("a_cpu_run",        {31'd0, cpu_run_o}, 32'd1);
    check("a_busy_clear",     {31'd0, busy_o},    32'd0);
    check("a_ready_in_done",  {31'd0, in_ready_o}, 32'd0);
    check("a_write_count",    32'(wr_cnt - wr_base), 32'd2);

    // B: same load with random stalls
    exp_addr_q.push_back(32'h0); exp_q.push_back(32'h2008_0005);
    exp_addr_q.push_back(32'h4); exp_q.push_back(32'h0109_5020);
    wr_base = wr_cnt;
    pulse_start();
    @(negedge clk);
    check("b_done_cleared", {31'd0, done_o}, 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h2008_0005, 1'b1);
    send_word(32'h0109_5020, 1'b1);
    wait_done("b_done");
    check("b_write_count", 32'(wr_cnt - wr_base), 32'd2);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);

    // C: count=0
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("c_done",        {31'd0, done_o}, 32'd1);
    check("c_busy",        {31'd0, busy_o}, 32'd0);
    check("c_no_write",    32'(wr_cnt - wr_base), 32'd0);

    // D: count=DEPTH+1, then recover
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    check("d_err",         {31'd0, err_o},      32'd1);
    check("d_cpu_run",     {31'd0, cpu_run_o},  32'd0);
    check("d_ready",       {31'd0, in_ready_o}, 32'd0);
    check("d_no_write",    32'(wr_cnt - wr_base), 32'd0);
    exp_addr_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF);
    pulse_start();
    @(negedge clk);
    check("d_err_cleared", {31'd0, err_o},  32'd0);
    check("d_busy",        {31'd0, busy_o}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done("d_reload_done");

    // E: reset after 6 of 8 data bytes
    wr_base = wr_cnt;
    exp_addr_q.push_back(32'h0); exp_q.push_back(32'h1122_3344);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("e_async_reset");
    check("e_one_write", 32'(wr_cnt - wr_base), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0); exp_q.push_back(32'hCAFE_F00D);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_done("e_reload_done");

    // F: start with a LEN_HI byte, and start during DATA, are both ignored
    wr_base = wr_cnt;
    exp_addr_q.push_back(32'h0); exp_q.push_back(32'hA0A1_A2A3);
    exp_addr_q.push_back(32'h4); exp_q.push_back(32'hB0B1_B2B3);
    exp_addr_q.push_back(32'h8); exp_q.push_back(32'hC0C1_C2C3);
    pulse_start();
    @(negedge clk);
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 8'h00;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    check("f_state_len_lo", {29'd0, dbg_state_o}, 32'd2);
    send_byte(8'h03, 1'b0);
    send_word(32'hA0A1_A2A3, 1'b0);
    send_byte(8'hB0, 1'b0);
    send_byte(8'hB1, 1'b0);
    pulse_start();
    check("f_busy_kept", {31'd0, busy_o}, 32'd1);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_word(32'hC0C1_C2C3, 1'b0);
    wait_done("f_done");
    check("f_write_count", 32'(wr_cnt - wr_base), 32'd3);
    check("f_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
